// File: rtl/uart_transceiver_cfg.sv
// Full-duplex 16x oversampled UART with runtime parity/stop config, 3-sample
// majority RX, framing/parity/break detection and a TX break generator.
module uart_transceiver_cfg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rx,
  output logic              uart_tx,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_busy,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_break,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  input  logic              tx_break,
  output logic              tx_done,
  output logic              tx_busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRKWAIT
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2, TX_BREAK
  } tx_state_e;

  // Oversampling tick generator; divisor 0 or 1 ticks every cycle
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_reload_c;
  logic             tick_c;

  assign div_reload_c = (divisor > DIV_W'(1)) ? (divisor - DIV_W'(1)) : '0;
  assign tick_c       = (div_cnt_q == '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_q <= div_reload_c;
    end else if (tick_c) begin
      div_cnt_q <= div_reload_c;
    end else begin
      div_cnt_q <= div_cnt_q - DIV_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous serial input
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------- receiver
  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [2:0]        rx_samp_q, rx_samp_d;
  logic              rx_par_q, rx_par_d;
  logic              rx_pen_q, rx_pen_d;
  logic              rx_odd_q, rx_odd_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_busy_q, rx_busy_d;
  logic              rx_ferr_q, rx_ferr_d;
  logic              rx_perr_q, rx_perr_d;
  logic              rx_brk_q, rx_brk_d;
  logic              rx_maj_c;

  assign rx_maj_c = (rx_samp_q[0] & rx_samp_q[1]) |
                    (rx_samp_q[0] & rx_samp_q[2]) |
                    (rx_samp_q[1] & rx_samp_q[2]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_samp_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      rx_busy_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_samp_q  <= rx_samp_d;
      rx_par_q   <= rx_par_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      rx_busy_q  <= rx_busy_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  // RX next state: samples at sub-bit 7/8/9, bit decided at sub-bit 15
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_samp_d  = rx_samp_q;
    rx_par_d   = rx_par_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    rx_busy_d  = rx_busy_q;
    rx_ferr_d  = rx_ferr_q;
    rx_perr_d  = rx_perr_q;
    rx_brk_d   = rx_brk_q;

    unique case (rx_state_q)
      RX_IDLE: begin
        if (tick_c && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_busy_d  = 1'b1;
          rx_pen_d   = (parity_mode == 2'd1) || (parity_mode == 2'd2);
          rx_odd_d   = (parity_mode == 2'd2);
        end
      end
      RX_BRKWAIT: begin
        if (tick_c && rx_sync_q) begin
          rx_state_d = RX_IDLE;
          rx_busy_d  = 1'b0;
        end
      end
      default: begin
        if (tick_c) begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
          if ((rx_cnt_q >= CNT_W'(7)) && (rx_cnt_q <= CNT_W'(9))) begin
            rx_samp_d[2'(rx_cnt_q - CNT_W'(7))] = rx_sync_q;
          end
          if (rx_cnt_q == CNT_W'(15)) begin
            case (rx_state_q)
              RX_START: begin
                if (rx_maj_c) begin
                  rx_state_d = RX_IDLE;
                  rx_busy_d  = 1'b0;
                end else begin
                  rx_state_d = RX_DATA;
                  rx_bit_d   = '0;
                end
              end
              RX_DATA: begin
                rx_shift_d = {rx_maj_c, rx_shift_q[DATA_W-1:1]};
                if (rx_bit_q == BIT_W'(DATA_W - 1)) begin
                  rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
                end else begin
                  rx_bit_d = rx_bit_q + BIT_W'(1);
                end
              end
              RX_PARITY: begin
                rx_par_d   = rx_maj_c;
                rx_state_d = RX_STOP;
              end
              RX_STOP: begin
                rx_data_d = rx_shift_q;
                rx_done_d = 1'b1;
                rx_ferr_d = !rx_maj_c;
                rx_perr_d = rx_pen_q & (^rx_shift_q ^ rx_par_q ^ rx_odd_q);
                rx_brk_d  = !rx_maj_c && (rx_shift_q == '0) && (!rx_pen_q || !rx_par_q);
                if (!rx_maj_c && (rx_shift_q == '0) && (!rx_pen_q || !rx_par_q)) begin
                  rx_state_d = RX_BRKWAIT;
                end else begin
                  rx_state_d = RX_IDLE;
                  rx_busy_d  = 1'b0;
                end
              end
              default: rx_state_d = RX_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  assign rx_data       = rx_data_q;
  assign rx_done       = rx_done_q;
  assign rx_busy       = rx_busy_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_break      = rx_brk_q;

  // ------------------------------------------------------------- transmitter
  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_pen_q, tx_pen_d;
  logic              tx_s2_q, tx_s2_d;
  logic              tx_line_q, tx_line_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_hold_q, tx_hold_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_s2_q    <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_hold_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
      tx_s2_q    <= tx_s2_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
      tx_hold_q  <= tx_hold_d;
    end
  end

  // TX next state: line value is computed for the bit being entered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_s2_d    = tx_s2_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    tx_hold_d  = tx_hold_q;

    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
          tx_shift_d = tx_data;
          tx_pen_d   = (parity_mode == 2'd1) || (parity_mode == 2'd2);
          tx_s2_d    = stop2;
          tx_par_d   = ^tx_data ^ (parity_mode == 2'd2);
        end else if (tx_break) begin
          tx_state_d = TX_BREAK;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
          tx_hold_d  = 1'b0;
        end
      end
      // Break: line low while requested, then one idle bit time still busy
      TX_BREAK: begin
        if (!tx_hold_q) begin
          if (!tx_break) begin
            tx_hold_d = 1'b1;
            tx_line_d = 1'b1;
            tx_cnt_d  = '0;
          end
        end else if (tick_c) begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          if (tx_cnt_q == CNT_W'(15)) begin
            tx_state_d = TX_IDLE;
            tx_busy_d  = 1'b0;
            tx_hold_d  = 1'b0;
          end
        end
      end
      default: begin
        if (tick_c) begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          if (tx_cnt_q == CNT_W'(15)) begin
            case (tx_state_q)
              TX_START: begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
                tx_line_d  = tx_shift_q[0];
              end
              TX_DATA: begin
                if (tx_bit_q == BIT_W'(DATA_W - 1)) begin
                  tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP1;
                  tx_line_d  = tx_pen_q ? tx_par_q : 1'b1;
                end else begin
                  tx_bit_d   = tx_bit_q + BIT_W'(1);
                  tx_shift_d = tx_shift_q >> 1;
                  tx_line_d  = tx_shift_q[1];
                end
              end
              TX_PARITY: begin
                tx_state_d = TX_STOP1;
                tx_line_d  = 1'b1;
              end
              TX_STOP1: begin
                if (tx_s2_q) begin
                  tx_state_d = TX_STOP2;
                end else begin
                  tx_state_d = TX_IDLE;
                  tx_busy_d  = 1'b0;
                  tx_done_d  = 1'b1;
                end
              end
              TX_STOP2: begin
                tx_state_d = TX_IDLE;
                tx_busy_d  = 1'b0;
                tx_done_d  = 1'b1;
              end
              default: tx_state_d = TX_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  assign uart_tx = tx_line_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: doc/uart_transceiver_cfg.md
Name: uart_transceiver_cfg

Overview:
Parametrised successor UART transceiver: full-duplex, 16x oversampled, runtime-selectable parity (none/even/odd) and stop bits (1/2). Adds 3-sample majority voting, framing/parity/break detection, and a TX break generator. Sits between the CSR bus UART front-end and the pads; one instance per serial port.

Parameters:
DATA_W, 8, data bits per frame, legal 5..9, LSB first
DIV_W, 16, width of divisor input and tick counter

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial input, asynchronous to sys_clk
uart_tx  out  1  serial output, idle high
divisor  in  DIV_W  sys_clk cycles per 1/16 bit
parity_mode  in  2  0=none, 1=even, 2=odd, 3=treated as none
stop2  in  1  1=two stop bits on TX (RX checks first stop only)
rx_data  out  DATA_W  last received word
rx_done  out  1  one-cycle pulse, frame complete
rx_busy  out  1  RX frame in progress
rx_frame_err  out  1  stop-bit majority was 0, valid with rx_done
rx_parity_err  out  1  parity mismatch, valid with rx_done
rx_break  out  1  break detected, valid with rx_done
tx_data  in  DATA_W  word to send
tx_wr  in  1  write strobe
tx_break  in  1  hold line low while asserted and TX idle
tx_done  out  1  one-cycle pulse, last stop bit complete
tx_busy  out  1  TX frame in progress

Behaviour:
- One clock; reset is asynchronous and active-low. Reset: uart_tx=1, all other outputs 0; tick counter=divisor-1; FSMs IDLE.
- Tick: counter decrements each cycle; at 0 asserts tick and reloads divisor-1. divisor 0 or 1 -> tick every cycle.
- uart_rx passes 2-flop synchroniser (rxs), reset value 1; 2-cycle input latency.
- Config (parity_mode, stop2) latched per direction at frame start; mid-frame changes ignored.
- RX FSM: IDLE, START, DATA, PARITY, STOP, BRKWAIT. Sub-bit counter cnt (4 bit) advances on tick only.
- IDLE: on tick with rxs=0 -> START, cnt=0, rx_busy=1.
- Every state: rxs sampled on ticks at cnt 7,8,9; bit value = majority of 3; evaluated at cnt 15, then cnt wraps to 0.
- START: majority 1 -> false start, IDLE, rx_busy=0, no rx_done. Else DATA.
- DATA: shift DATA_W bits LSB first; then PARITY if enabled, else STOP.
- PARITY: even -> XOR(data,parity bit) must be 0; odd -> must be 1.
- STOP at cnt 15: rx_data, flags updated, rx_done pulses 1 cycle. frame_err = stop majority 0. rx_break = frame_err && data all 0 && (parity bit 0 or none). Break -> BRKWAIT, else IDLE. rx_busy=0 same cycle.
- BRKWAIT: rx_busy stays 1 until tick with rxs=1, then IDLE; no further rx_done.
- Flags and rx_data hold until next rx_done.
- TX FSM: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- tx_wr accepted only when tx_busy=0; while busy it is ignored (no restart). Accept: next cycle uart_tx=0, tx_busy=1, cnt=0.
- Each bit lasts exactly 16 ticks; first tick counted is the first after accept. Order: start, DATA_W bits LSB first, parity (if enabled), stop1, stop2 (if stop2).
- After final stop bit's 16th tick: tx_done pulses 1 cycle, tx_busy=0 same cycle; a tx_wr that cycle is accepted.
- tx_break in IDLE with no tx_wr: uart_tx=0, tx_busy=1 while asserted; on release uart_tx=1, tx_busy held for 16 ticks, then IDLE; no tx_done. tx_wr wins if simultaneous with tx_break.
- Async reset mid-frame aborts both FSMs immediately; no done pulse.

Test Plan:
- divisor=4, DATA_W=8, none, 1 stop, tx_wr 0xA5 -> uart_tx 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles; tx_done after 640 cycles; loopback rx_data=0xA5, flags 0.
- parity_mode=1, stop2=1, tx 0x07 -> parity bit 1, two stop bits; RX with injected parity bit 0 -> rx_parity_err=1, rx_data=0x07.
- RX 1-tick low glitch while idle -> no rx_done, rx_busy back to 0; single-tick glitch mid-bit at sample 8 -> masked by majority, data correct.
- RX stop bit forced 0, data 0x3C -> rx_done with rx_frame_err=1, rx_break=0; line low for 20 bit times -> rx_break=1 once, rx_busy held until line high.
- tx_wr pulsed while tx_busy -> ignored, frame unchanged; tx_wr on tx_done cycle -> back-to-back frame, no idle gap.
- Reset asserted mid TX/RX frame -> uart_tx=1, busy=0 immediately; divisor=0 -> tick every cycle, 16-cycle bits.
